mac_cell: RTL
=============

# mac_cell

Parametrised fixed-point multiply-accumulate cell for the LeNet-5 convolution and FC datapath. Accepts a stream of signed (input, weight) pairs, accumulates `TAPS` products plus a bias at full precision, then rounds, rescales and saturates the sum back to `DATA_WIDTH` and emits it with a one-cycle valid pulse. It replaces a bare registered multiply-and-slice stage. It adds programmable fraction position, rounding, saturation, bias and window counting.

## Interface
- `DATA_WIDTH`, 16: width of data, weight, bias and result, signed two's complement.
- `FRAC_BITS`, 12: fractional bits of data, weight, bias and result (Q4.12 at defaults).
- `TAPS`, 25: products per output window (5x5 kernel). Must be ≥1.
- `ACC_WIDTH`, 40: accumulator width. Must be ≥ 2*DATA_WIDTH + ceil(log2(TAPS+1)); violation is an elaboration error.
- `ROUND`, 1: 1 = round-half-up before the shift; 0 = truncate (arithmetic shift).
- `SATURATE`, 1: 1 = clamp to the result range; 0 = wrap (keep the low DATA_WIDTH bits).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort of the current window and all in-flight work.
- `in_valid`  in  1  `in_data` and `in_weight` carry a tap this cycle.
- `in_data`  in  DATA_WIDTH  signed activation.
- `in_weight`  in  DATA_WIDTH  signed weight.
- `in_bias`  in  DATA_WIDTH  signed bias; sampled only with tap 0 of a window.
- `out_valid`  out  1  one-cycle pulse; `out_data` holds a finished result.
- `out_data`  out  DATA_WIDTH  rounded, rescaled, saturated result.
- `out_sat`  out  1  saturation (or wrap, when SATURATE=0) occurred for this result; valid with `out_valid`.
- `busy`  out  1  tap counter is non-zero or a product or accumulation is in flight.

## Operation
- Tap counter `cnt` (0..TAPS-1) advances on each accepted tap (`in_valid`=1, `clear`=0). It wraps to 0 after TAPS-1. Tap 0 is tagged `first` and tap TAPS-1 is tagged `last`; with TAPS=1 a tap is both.
- **Stage P**: full-precision signed product `in_data*in_weight` (2*DATA_WIDTH bits) is registered, together with `p_valid`, `p_first`, `p_last` and, on `first`, `in_bias`.
- **Stage A**: the product is sign-extended to ACC_WIDTH.
  - If `p_first`: `acc <= (bias sign-extended) << FRAC_BITS + product`. This overwrites `acc` and never adds to the old value.
  - Otherwise: `acc <= acc + product`.
  - `a_last` is registered from `p_last`.
- **Stage O**: runs when `a_last`=1.
  - `r = acc + (ROUND ? 2^(FRAC_BITS-1) : 0)`, then `s = r >>> FRAC_BITS`.
  - With SATURATE, `s` is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and `out_sat` is set when clamped.
  - With wrap, `out_sat` flags a lost upper bit.
  - `out_data` and `out_sat` hold until the next result.
- Bubbles (`in_valid`=0) inside a window are allowed for any number of cycles and change no state except draining the pipeline.
- `clear`:
  - Sets `cnt`, `p_valid` and `a_last` to 0 and suppresses any `out_valid` from an aborted window.
  - A tap presented in the same cycle as `clear` is discarded.
  - `out_data` and `out_sat` keep their last values.
- Reset values: `cnt`=0, all valid tags and `a_last`=0, `acc`=0, `out_valid`=0, `out_data`=0, `out_sat`=0, `busy`=0. Reset mid-window discards that window entirely.

## Timing
- Tap accepted at edge E → product registered at E → accumulator updated at E+1 → `out_data`/`out_valid` registered at E+2 (for the last tap).
  - `out_valid` is high for exactly the cycle after E+2.
  - Latency from the last tap to the result is 3 cycles at full throughput.
- Throughput is one tap per cycle, and windows run back-to-back with no bubble. The first tap of window n+1 may follow the last tap of window n on the next edge. Stage O reads `acc` at E+2 while Stage A overwrites it at the same edge.
- No backpressure: the consumer must accept `out_valid` unconditionally.
- `busy` is combinational from `cnt` and the valid tags. It deasserts the cycle `out_valid` is high if no new tap was accepted.

## Test plan
- Defaults; 25 taps of 0x0800 × 0x0800, bias 0 → one `out_valid`, 3 cycles after the last tap; `out_data`=0x6400 (6.25); `out_sat`=0.
- 25 taps of 0x1000 × 0x1000 (sum 25.0) → `out_data`=0x7FFF, `out_sat`=1. Same taps with in_data=0x8000 (sum −200.0) → 0x8000, `out_sat`=1. With SATURATE=0, the positive case gives 0x9000 and `out_sat`=1.
- Rounding with TAPS=1, bias 0, tap 0x0001 × 0x0800:
  - ROUND=1 → 0x0001.
  - ROUND=0 → 0x0000.
  - Tap 0xFFFF × 0x0800 with ROUND=1 → 0x0000.
- Three back-to-back windows with random taps, biases and random `in_valid` bubbles → results match a bit-exact reference model, each exactly 3 cycles after its last tap; the first tap always overwrites `acc`.
- Pulse `clear` after tap 10, together with a tap; then run a full window with bias 0x1000 → no `out_valid` for the aborted window; the next result equals bias + 25 products.
- Assert `rst_n`=0 asynchronously mid-window and mid-pipeline (`a_last`=1) → outputs immediately 0, no pulse after release; the next window is correct from tap 0.

Source files
------------

// File: rtl/mac_cell.sv
// mac_cell: signed fixed-point multiply-accumulate cell.
// Accumulates TAPS products of (in_data * in_weight) plus a bias at full
// precision. The sum is then rounded, rescaled by FRAC_BITS and saturated
// (or wrapped) to DATA_WIDTH, and the result is emitted with a one-cycle
// out_valid pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort of the current window and in-flight work
//   in_valid   in_data/in_weight carry a tap this cycle
//   in_data    signed activation
//   in_weight  signed weight
//   in_bias    signed bias, sampled with tap 0 of a window
//   out_valid  one-cycle pulse, out_data holds a finished result
//   out_data   rounded, rescaled, saturated result (held until the next one)
//   out_sat    result was clamped (or wrapped when SATURATE=0)
//   busy       tap counter non-zero or work in flight
module mac_cell #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12,
  parameter int TAPS       = 25,
  parameter int ACC_WIDTH  = 40,
  parameter int ROUND      = 1,
  parameter int SATURATE   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic signed [DATA_WIDTH-1:0] in_weight,
  input  logic signed [DATA_WIDTH-1:0] in_bias,
  output logic                         out_valid,
  output logic        [DATA_WIDTH-1:0] out_data,
  output logic                         out_sat,
  output logic                         busy
);

  localparam int CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int S_W    = ACC_WIDTH - FRAC_BITS;
  localparam int UP_W   = S_W - DATA_WIDTH + 1;

  localparam logic [ACC_WIDTH-1:0] RND =
    (ROUND != 0 && FRAC_BITS > 0) ?
      (ACC_WIDTH'(1) << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0)) : '0;
  localparam logic [DATA_WIDTH-1:0] RES_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] RES_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  if (TAPS < 1) begin : g_bad_taps
    $error("mac_cell: TAPS must be at least 1");
  end
  if (ACC_WIDTH < PROD_W + $clog2(TAPS + 1)) begin : g_bad_acc
    $error("mac_cell: ACC_WIDTH too narrow for TAPS products");
  end

  // Tap counter and window tags
  logic [CNT_W-1:0] cnt;
  logic             tap_first;
  logic             tap_last;

  assign tap_first = (cnt == '0);
  assign tap_last  = (cnt == CNT_W'(TAPS - 1));

  // Stage P registers
  logic                         p_valid;
  logic                         p_first;
  logic                         p_last;
  logic signed [PROD_W-1:0]     p_prod;
  logic signed [DATA_WIDTH-1:0] p_bias;
  logic signed [PROD_W-1:0]     prod;

  assign prod = in_data * in_weight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      p_prod  <= '0;
      p_bias  <= '0;
    end else if (clear) begin
      cnt     <= '0;
      p_valid <= 1'b0;
    end else begin
      p_valid <= in_valid;
      if (in_valid) begin
        p_prod  <= prod;
        p_first <= tap_first;
        p_last  <= tap_last;
        if (tap_first) begin
          p_bias <= in_bias;
        end
        cnt <= tap_last ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  // Stage A: the first tap of a window reloads acc from the bias, so a
  // back-to-back window never sees the previous sum.
  logic [ACC_WIDTH-1:0] acc;
  logic                 a_last;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] bias_base;

  assign prod_ext  = {{(ACC_WIDTH-PROD_W){p_prod[PROD_W-1]}}, p_prod};
  assign bias_base = {{(ACC_WIDTH-DATA_WIDTH){p_bias[DATA_WIDTH-1]}}, p_bias}
                     << FRAC_BITS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      a_last <= 1'b0;
    end else if (clear) begin
      a_last <= 1'b0;
    end else begin
      a_last <= p_valid & p_last;
      if (p_valid) begin
        acc <= (p_first ? bias_base : acc) + prod_ext;
      end
    end
  end

  // Stage O. Dropping the low FRAC_BITS of the rounded sum is the arithmetic
  // shift. The result fits when every bit above the result's sign bit
  // matches that sign bit.
  logic [S_W-1:0]        s;
  logic [UP_W-1:0]       s_upper;
  logic                  fits;
  logic [DATA_WIDTH-1:0] res;

  assign s       = S_W'((acc + RND) >> FRAC_BITS);
  assign s_upper = s[S_W-1:DATA_WIDTH-1];
  assign fits    = (&s_upper) | ~(|s_upper);

  always_comb begin
    res = s[DATA_WIDTH-1:0];
    if (SATURATE != 0 && !fits) begin
      res = s[S_W-1] ? RES_MIN : RES_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= a_last & ~clear;
      if (a_last && !clear) begin
        out_data <= res;
        out_sat  <= ~fits;
      end
    end
  end

  assign busy = (cnt != '0) | p_valid | a_last;

endmodule
